// File: rtl/branch_flag_resolver.sv
// Branch resolve unit: evaluates B.cond/CBZ/CBNZ/B against effective N/Z/C/V flags and sequences the flush.
// Optional saturating statistics counters are built only when BR_STATS_EN is defined.
module branch_flag_resolver #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [1:0]        br_kind,
  input  logic [3:0]        br_cond,
  input  logic              reg_zero,
  input  logic              pipe_stall,
  input  logic              flags_pending,
  input  logic              fwd_flagEn,
  input  logic              fwd_neg,
  input  logic              fwd_zero,
  input  logic              fwd_overflow,
  input  logic              fwd_carry,
  input  logic              negFlag,
  input  logic              zeroFlag,
  input  logic              overflowFlag,
  input  logic              carry_outFlag,
  output logic              resolve_valid,
  output logic              take_branch,
  output logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] resolved_cnt,
  output logic [1:0]        dbgState
);

  // Handshake: a branch is consumed on a clock edge where the unit accepts it; while
  // stall_req is high the pipeline keeps br_valid/br_kind/br_cond stable in this stage.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  state_t     state, nextState;
  logic [2:0] flushCnt, nextFlushCnt;
  logic       effN, effZ, effC, effV;
  logic       condMet, decision, isCond, accept;

  always_comb begin
    effN = fwd_flagEn ? fwd_neg      : negFlag;
    effZ = fwd_flagEn ? fwd_zero     : zeroFlag;
    effC = fwd_flagEn ? fwd_carry    : carry_outFlag;
    effV = fwd_flagEn ? fwd_overflow : overflowFlag;

    case (br_cond)
      4'h0:    condMet = effZ;
      4'h1:    condMet = !effZ;
      4'h2:    condMet = effC;
      4'h3:    condMet = !effC;
      4'h4:    condMet = effN;
      4'h5:    condMet = !effN;
      4'h6:    condMet = effV;
      4'h7:    condMet = !effV;
      4'h8:    condMet = effC && !effZ;
      4'h9:    condMet = !(effC && !effZ);
      4'hA:    condMet = (effN == effV);
      4'hB:    condMet = (effN != effV);
      4'hC:    condMet = !effZ && (effN == effV);
      4'hD:    condMet = !(!effZ && (effN == effV));
      default: condMet = 1'b1;
    endcase

    case (br_kind)
      2'b00:   decision = condMet;
      2'b01:   decision = reg_zero;
      2'b10:   decision = !reg_zero;
      default: decision = 1'b1;
    endcase
  end

  assign isCond = (br_kind == 2'b00);

  always_comb begin
    nextState    = state;
    nextFlushCnt = flushCnt;
    accept       = 1'b0;
    stall_req    = 1'b0;
    case (state)
      IDLE: begin
        stall_req = br_valid && isCond && flags_pending;
        if (br_valid && !pipe_stall) begin
          if (isCond && flags_pending) nextState = WAIT;
          else                         accept    = 1'b1;
        end
      end
      // The accept cycle itself releases the stall so the branch can leave the stage.
      WAIT: begin
        stall_req = flags_pending;
        if (!flags_pending) accept = 1'b1;
      end
      FLUSH: begin
        if (flushCnt == 3'd0) nextState    = IDLE;
        else                  nextFlushCnt = flushCnt - 3'd1;
      end
      default: nextState = IDLE;
    endcase

    if (accept) begin
      if (decision) begin
        nextState    = FLUSH;
        nextFlushCnt = FlushLoad;
      end else begin
        nextState = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      flushCnt      <= 3'd0;
      resolve_valid <= 1'b0;
      take_branch   <= 1'b0;
    end else begin
      state         <= nextState;
      flushCnt      <= nextFlushCnt;
      resolve_valid <= accept;
      if (accept) take_branch <= decision;
    end
  end

  assign flush    = (state == FLUSH);
  assign busy     = (state != IDLE);
  assign dbgState = state;

`ifdef BR_STATS_EN
  // Counts advance on the accept edge so they line up with the resolve_valid pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_cnt    <= '0;
      resolved_cnt <= '0;
    end else if (accept) begin
      if (resolved_cnt != '1) resolved_cnt <= resolved_cnt + 1'b1;
      if (decision && taken_cnt != '1) taken_cnt <= taken_cnt + 1'b1;
    end
  end
`else
  assign taken_cnt    = '0;
  assign resolved_cnt = '0;
`endif

endmodule
